// File: rtl/gate_vector_checker_pkg.sv
// gate_check_pkg
//   Shared encodings for the gate vector checker.
//   op_t    : bitwise operation selected for a run (OR/AND/XOR/NAND)
//   state_t : run-control FSM states
package gate_check_pkg;

    typedef enum logic [1:0] {
        OP_OR   = 2'b00,
        OP_AND  = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/gate_vector_checker_if.sv
// gate_vector_checker_if
//   Valid/ready channel carrying (A, B, Y) vector tuples into the checker.
//   vec_valid : tuple fields are valid
//   vec_ready : checker accepts a tuple this cycle
//   vec_last  : final tuple of the run
//   vec_a     : operand A
//   vec_b     : operand B
//   vec_y     : result produced by the gate under test
//   master drives the tuple, slave (the checker) drives vec_ready.
interface gate_vector_checker_if #(
    parameter int WIDTH = 16
);
    logic             vec_valid;
    logic             vec_ready;
    logic             vec_last;
    logic [WIDTH-1:0] vec_a;
    logic [WIDTH-1:0] vec_b;
    logic [WIDTH-1:0] vec_y;

    modport master (
        output vec_valid, vec_last, vec_a, vec_b, vec_y,
        input  vec_ready
    );

    modport slave (
        input  vec_valid, vec_last, vec_a, vec_b, vec_y,
        output vec_ready
    );
endinterface

// File: rtl/gate_vector_checker_ref_gate16.sv
// ref_gate16
//   Combinational reference gate: recomputes the expected result of the
//   selected bitwise operation over the full width.
//   op       : in   operation select (op_t)
//   a, b     : in   operands
//   expected : out  op applied bitwise to a and b
module ref_gate16
    import gate_check_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] expected
);

    always_comb begin
        expected = '0;
        case (op)
            OP_OR:   expected = a | b;
            OP_AND:  expected = a & b;
            OP_XOR:  expected = a ^ b;
            OP_NAND: expected = ~(a & b);
            default: expected = '0;
        endcase
    end

endmodule

// File: rtl/gate_vector_checker.sv
// gate_vector_checker
//   Response checker for gate-level stimulus/response runs. Accepts (A, B, Y)
//   tuples, recomputes the expected value for the latched op, counts passes
//   and failures, captures the first mismatch and reports completion.
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start          : clears results, latches op_sel, enters RUN
//   op_sel         : 00=OR 01=AND 10=XOR 11=NAND, sampled on start
//   vec_if         : tuple channel (slave side)
//   pass_count     : matching tuples this run (saturating)
//   fail_count     : mismatching tuples this run (saturating)
//   fail_seen      : at least one mismatch this run
//   first_fail_idx : 0-based index of the first mismatching tuple
//   first_fail_y   : vec_y of the first mismatch
//   first_fail_exp : expected value of the first mismatch
//   busy           : state is RUN or DRAIN
//   done           : state is DONE
module gate_vector_checker
    import gate_check_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op_sel,
    gate_vector_checker_if.slave  vec_if,
    output logic [CNT_W-1:0]      pass_count,
    output logic [CNT_W-1:0]      fail_count,
    output logic                  fail_seen,
    output logic [CNT_W-1:0]      first_fail_idx,
    output logic [WIDTH-1:0]      first_fail_y,
    output logic [WIDTH-1:0]      first_fail_exp,
    output logic                  busy,
    output logic                  done
);

    state_t           state;
    state_t           state_next;
    op_t              op_reg;
    logic             accept;
    logic [WIDTH-1:0] expected;
    logic [CNT_W-1:0] idx;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_y;
    logic [WIDTH-1:0] s1_exp;
    logic [CNT_W-1:0] s1_idx;

    // A start on the same edge as a transfer wins, so the tuple is not taken.
    assign vec_if.vec_ready = (state == ST_RUN);
    assign accept           = vec_if.vec_valid && (state == ST_RUN) && !start;

    ref_gate16 #(.WIDTH(WIDTH)) u_ref (
        .op       (op_reg),
        .a        (vec_if.vec_a),
        .b        (vec_if.vec_b),
        .expected (expected)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and status outputs. start restarts the run from any state;
    // DRAIN lasts exactly one cycle so the last compare can retire.
    always_comb begin
        state_next = state;
        busy       = (state == ST_RUN) || (state == ST_DRAIN);
        done       = (state == ST_DONE);
        if (start) begin
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (accept && vec_if.vec_last) state_next = ST_DRAIN;
                ST_DRAIN: state_next = ST_DONE;
                default:  state_next = state;
            endcase
        end
    end

    // Stage 1 holds the accepted tuple with its expected value; the compare
    // updates counters and the first-mismatch capture on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg         <= OP_OR;
            idx            <= '0;
            s1_valid       <= 1'b0;
            s1_y           <= '0;
            s1_exp         <= '0;
            s1_idx         <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
            first_fail_y   <= '0;
            first_fail_exp <= '0;
        end else if (start) begin
            op_reg         <= op_t'(op_sel);
            idx            <= '0;
            s1_valid       <= 1'b0;
            pass_count     <= '0;
            fail_count     <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
            first_fail_y   <= '0;
            first_fail_exp <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_y   <= vec_if.vec_y;
                s1_exp <= expected;
                s1_idx <= idx;
                if (idx != '1) idx <= idx + 1'b1;
            end
            if (s1_valid) begin
                if (s1_y == s1_exp) begin
                    if (pass_count != '1) pass_count <= pass_count + 1'b1;
                end else begin
                    if (fail_count != '1) fail_count <= fail_count + 1'b1;
                    if (!fail_seen) begin
                        fail_seen      <= 1'b1;
                        first_fail_idx <= s1_idx;
                        first_fail_y   <= s1_y;
                        first_fail_exp <= s1_exp;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker
//   Bench for gate_vector_checker: directed runs, randomized runs checked
//   against a run-level reference model, abort/collision, async reset and a
//   CNT_W=2 instance for counter saturation.
module tb_gate_vector_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op_sel;
    logic [15:0] pass_count, fail_count, first_fail_idx;
    logic [15:0] first_fail_y, first_fail_exp;
    logic        fail_seen, busy, done;

    logic        s_start;
    logic [1:0]  s_op_sel;
    logic [1:0]  s_pass_count, s_fail_count, s_first_fail_idx;
    logic [15:0] s_first_fail_y, s_first_fail_exp;
    logic        s_fail_seen, s_busy, s_done;

    int tests_run;
    int tests_failed;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] qy[$];

    gate_vector_checker_if #(.WIDTH(16)) vif ();
    gate_vector_checker_if #(.WIDTH(16)) s_vif ();

    gate_vector_checker #(.WIDTH(16), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .op_sel         (op_sel),
        .vec_if         (vif),
        .pass_count     (pass_count),
        .fail_count     (fail_count),
        .fail_seen      (fail_seen),
        .first_fail_idx (first_fail_idx),
        .first_fail_y   (first_fail_y),
        .first_fail_exp (first_fail_exp),
        .busy           (busy),
        .done           (done)
    );

    gate_vector_checker #(.WIDTH(16), .CNT_W(2)) dut_small (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (s_start),
        .op_sel         (s_op_sel),
        .vec_if         (s_vif),
        .pass_count     (s_pass_count),
        .fail_count     (s_fail_count),
        .fail_seen      (s_fail_seen),
        .first_fail_idx (s_first_fail_idx),
        .first_fail_y   (s_first_fail_y),
        .first_fail_exp (s_first_fail_exp),
        .busy           (s_busy),
        .done           (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference gate written straight from the op table.
    function automatic logic [15:0] refOp(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            2'd0:    return a | b;
            2'd1:    return a & b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one tuple for a cycle (inputs change on the falling edge).
    task automatic driveTuple(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] y, input logic last);
        vif.vec_valid = 1'b1;
        vif.vec_a     = a;
        vif.vec_b     = b;
        vif.vec_y     = y;
        vif.vec_last  = last;
        @(negedge clk);
        vif.vec_valid = 1'b0;
        vif.vec_last  = 1'b0;
    endtask

    task automatic pulseStart(input logic [1:0] op);
        start  = 1'b1;
        op_sel = op;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Sends the queued tuples (optionally after a start), valid toggling every
    // other cycle when gap is set, then checks the drain/done timing.
    task automatic applyStimulus(input logic [1:0] op, input bit gap, input bit do_start);
        if (do_start) pulseStart(op);
        for (int i = 0; i < qa.size(); i++) begin
            if (gap && i > 0) begin
                @(negedge clk);
                checkOutput("ready_gap", {31'd0, vif.vec_ready}, 32'd1);
            end
            checkOutput("ready_run", {31'd0, vif.vec_ready}, 32'd1);
            driveTuple(qa[i], qb[i], qy[i], (i == qa.size() - 1));
        end
        checkOutput("drain_busy", {30'd0, busy, done}, 32'd2);
        checkOutput("drain_ready", {31'd0, vif.vec_ready}, 32'd0);
        @(negedge clk);
        checkOutput("done_level", {30'd0, busy, done}, 32'd1);
    endtask

    // Run-level model: totals and first mismatch from the whole tuple list.
    task automatic checkRun(input string tag, input logic [1:0] op);
        int          exp_pass = 0;
        int          exp_fail = 0;
        bit          seen = 0;
        int          f_idx = 0;
        logic [15:0] f_y = '0;
        logic [15:0] f_exp = '0;
        for (int i = 0; i < qa.size(); i++) begin
            if (refOp(op, qa[i], qb[i]) == qy[i]) begin
                exp_pass++;
            end else begin
                exp_fail++;
                if (!seen) begin
                    seen  = 1;
                    f_idx = i;
                    f_y   = qy[i];
                    f_exp = refOp(op, qa[i], qb[i]);
                end
            end
        end
        checkOutput({tag, "_pass"}, {16'd0, pass_count}, exp_pass);
        checkOutput({tag, "_fail"}, {16'd0, fail_count}, exp_fail);
        checkOutput({tag, "_seen"}, {31'd0, fail_seen}, {31'd0, seen});
        checkOutput({tag, "_fidx"}, {16'd0, first_fail_idx}, f_idx);
        checkOutput({tag, "_fy"}, {16'd0, first_fail_y}, {16'd0, f_y});
        checkOutput({tag, "_fexp"}, {16'd0, first_fail_exp}, {16'd0, f_exp});
    endtask

    task automatic loadTuple(input logic [15:0] a, input logic [15:0] b, input logic [15:0] y);
        qa.push_back(a);
        qb.push_back(b);
        qy.push_back(y);
    endtask

    task automatic clearQueues();
        qa.delete();
        qb.delete();
        qy.delete();
    endtask

    initial begin
        logic [1:0]  rop;
        int          rlen;
        bit          rgap;
        logic [15:0] ra, rb, ry, rflip;

        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        op_sel       = 2'b00;
        s_start      = 1'b0;
        s_op_sel     = 2'b00;
        vif.vec_valid = 1'b0; vif.vec_last = 1'b0;
        vif.vec_a = '0; vif.vec_b = '0; vif.vec_y = '0;
        s_vif.vec_valid = 1'b0; s_vif.vec_last = 1'b0;
        s_vif.vec_a = '0; s_vif.vec_b = '0; s_vif.vec_y = '0;

        // Reset values.
        #12;
        checkOutput("rst_counts", {pass_count, fail_count}, 32'd0);
        checkOutput("rst_flags", {28'd0, fail_seen, busy, done, vif.vec_ready}, 32'd0);
        checkOutput("rst_capture", {first_fail_y, first_fail_exp}, 32'd0);
        checkOutput("rst_fidx", {16'd0, first_fail_idx}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed OR run, all passing.
        clearQueues();
        loadTuple(16'h5555, 16'h5555, 16'h5555);
        loadTuple(16'hCCCC, 16'h5555, 16'hDDDD);
        loadTuple(16'h85DD, 16'hFFFF, 16'hFFFF);
        loadTuple(16'h0515, 16'h0000, 16'h0515);
        applyStimulus(2'd0, 1'b0, 1'b1);
        checkOutput("or_pass_const", {16'd0, pass_count}, 32'd4);
        checkRun("or", 2'd0);

        // Valid outside RUN is ignored.
        vif.vec_valid = 1'b1; vif.vec_a = 16'h0001; vif.vec_b = '0; vif.vec_y = 16'hFFFF;
        repeat (3) @(negedge clk);
        vif.vec_valid = 1'b0;
        @(negedge clk);
        checkOutput("idle_valid_counts", {pass_count, fail_count}, {16'd4, 16'd0});
        checkOutput("idle_valid_done", {31'd0, done}, 32'd1);

        // Directed AND run with one mismatch.
        clearQueues();
        loadTuple(16'hFFFF, 16'h00FF, 16'h00FF);
        loadTuple(16'hF0F0, 16'h0FF0, 16'h0FF0);
        loadTuple(16'h1234, 16'hFFFF, 16'h1234);
        applyStimulus(2'd1, 1'b0, 1'b1);
        checkOutput("and_capture", {first_fail_y, first_fail_exp}, {16'h0FF0, 16'h00F0});
        checkRun("and", 2'd1);

        // XOR with valid toggling, two mismatches.
        clearQueues();
        loadTuple(16'h00FF, 16'h0F0F, 16'h0FF0);
        loadTuple(16'hAAAA, 16'h5555, 16'h0000);
        loadTuple(16'h1234, 16'h1234, 16'h0001);
        applyStimulus(2'd2, 1'b1, 1'b1);
        checkOutput("xor_first_idx", {16'd0, first_fail_idx}, 32'd1);
        checkRun("xor", 2'd2);

        // Mid-run abort, then a start colliding with a transfer.
        pulseStart(2'd0);
        driveTuple(16'h1111, 16'h2222, 16'h3333, 1'b0);
        driveTuple(16'h0000, 16'h0000, 16'hFFFF, 1'b0);
        pulseStart(2'd2);
        checkOutput("abort_counts", {pass_count, fail_count}, 32'd0);
        checkOutput("abort_flags", {30'd0, fail_seen, busy}, 32'd1);
        @(negedge clk);
        checkOutput("abort_inflight", {16'd0, fail_count}, 32'd0);
        vif.vec_valid = 1'b1; vif.vec_a = '0; vif.vec_b = '0; vif.vec_y = 16'h1234;
        vif.vec_last = 1'b1;
        pulseStart(2'd1);
        vif.vec_valid = 1'b0; vif.vec_last = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("collide_counts", {pass_count, fail_count}, 32'd0);
        checkOutput("collide_state", {30'd0, busy, done}, 32'd2);
        clearQueues();
        loadTuple(16'hFFFF, 16'h0F0F, 16'h0F0F);
        loadTuple(16'h3C3C, 16'hFF00, 16'h3C00);
        applyStimulus(2'd1, 1'b0, 1'b0);
        checkRun("relatch", 2'd1);

        // Randomized runs.
        for (int r = 0; r < 10; r++) begin
            clearQueues();
            rop  = 2'($urandom_range(0, 3));
            rlen = $urandom_range(1, 8);
            rgap = 1'($urandom_range(0, 1));
            for (int i = 0; i < rlen; i++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                ry = refOp(rop, ra, rb);
                if ($urandom_range(0, 9) < 3) begin
                    rflip = 16'($urandom) | 16'h0001;
                    ry = ry ^ rflip;
                end
                loadTuple(ra, rb, ry);
            end
            applyStimulus(rop, rgap, 1'b1);
            checkRun("rand", rop);
        end

        // Asynchronous reset mid-run.
        pulseStart(2'd3);
        driveTuple(16'h0000, 16'h0000, 16'hFFFF, 1'b0);
        driveTuple(16'h0F0F, 16'h0000, 16'hFFFF, 1'b0);
        vif.vec_valid = 1'b1; vif.vec_a = 16'hFFFF; vif.vec_b = 16'hFFFF; vif.vec_y = 16'h0000;
        @(negedge clk);
        checkOutput("midrun_pass", {16'd0, pass_count}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_counts", {pass_count, fail_count}, 32'd0);
        checkOutput("arst_flags", {28'd0, fail_seen, busy, done, vif.vec_ready}, 32'd0);
        vif.vec_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("arst_idle", {30'd0, busy, done}, 32'd0);

        // Saturation on the CNT_W=2 instance: five passing OR tuples.
        s_start = 1'b1; s_op_sel = 2'd0;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_vif.vec_valid = 1'b1;
            s_vif.vec_a     = 16'(i * 16'h0101);
            s_vif.vec_b     = 16'h0000;
            s_vif.vec_y     = 16'(i * 16'h0101);
            s_vif.vec_last  = (i == 4);
            @(negedge clk);
        end
        s_vif.vec_valid = 1'b0; s_vif.vec_last = 1'b0;
        @(negedge clk);
        checkOutput("sat_pass", {30'd0, s_pass_count}, 32'd3);
        checkOutput("sat_fail", {30'd0, s_fail_count}, 32'd0);
        checkOutput("sat_done", {30'd0, s_busy, s_done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
